// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, status bits, region sizes, FSM states.
package spi_flash_pkg;

  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SSE  = 8'h20;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_BE   = 8'hC7;
  localparam logic [7:0] OP_READ = 8'h03;

  localparam int STS_WIP = 0;
  localparam int STS_WEL = 1;

  localparam int unsigned SUBSECTOR_BYTES = 4096;
  localparam int unsigned SECTOR_BYTES    = 65536;

  typedef enum logic [3:0] {
    IDLE, OPCODE, ADDR2, ADDR1, ADDR0, READ, PROG, STATUS, IGNORE, ERASE_SWEEP, BUSY
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s = 8'h00;
    s[STS_WEL] = wel;
    s[STS_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave byte shifter: pin synchronizers, edge detect, bit framing and TX reload handshake.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  logic       sck_p0, sck_p1, sck_p2;
  logic       cs_p0, cs_p1, cs_p2;
  logic       mosi_p0, mosi_p1;
  logic       sck_rise, sck_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizers; p2: previous value for edge detect
      sck_p0  <= sck;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      cs_p0   <= cs_n;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign cs_fall  = ~cs_p1 & cs_p2;
  assign cs_rise  = cs_p1 & ~cs_p2;
  assign miso     = tx_sr[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      rx_sr      <= 7'd0;
      tx_sr      <= 8'd0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_p1) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 7'd0;
        tx_sr   <= 8'd0;
      end else begin
        if (sck_rise) begin
          rx_sr   <= {rx_sr[5:0], mosi_p1};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            rx_byte    <= {rx_sr, mosi_p1};
          end
        end
        // The fall right after a byte boundary must not shift, or the freshly loaded MSB is lost
        if (tx_load) tx_sr <= tx_data;
        else if (sck_fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash emulator: command decode, byte array, page program, erase sweep and WIP/WEL status.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int MEM_BYTES   = 4096,
  parameter int PROG_CYCLES = 64,
  parameter int ERASE_EXTRA = 32
) (
  input  logic i_wb_clk,
  input  logic i_wb_rst,
  input  logic SCK,
  input  logic CS_n,
  input  logic MOSI,
  output logic MISO,
  output logic o_wip,
  output logic o_wel,
  output logic o_cmd_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int unsigned SUB_CLIP = (SUBSECTOR_BYTES < MEM_BYTES) ? SUBSECTOR_BYTES : MEM_BYTES;
  localparam int unsigned SEC_CLIP = (SECTOR_BYTES < MEM_BYTES) ? SECTOR_BYTES : MEM_BYTES;

  logic          cs_fall, cs_rise, byte_valid, tx_load;
  logic [7:0]    rx_byte, tx_data, opcode;
  state_t        state, op_state;
  logic [23:0]   addr, addr_next;
  logic          wel, wip, cmd_err, commit_ok, prog_any;
  logic [15:0]   busy_cnt;
  logic [AW-1:0] sweep_idx, erase_base, mem_widx;
  logic [AW:0]   sweep_left, erase_size;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem [MEM_BYTES];

  spi_slave_shifter u_shifter (
    .clk        (i_wb_clk),
    .rst        (i_wb_rst),
    .sck        (SCK),
    .cs_n       (CS_n),
    .mosi       (MOSI),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .miso       (MISO),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  assign addr_next = {addr[15:0], rx_byte};
  assign o_wip     = wip;
  assign o_wel     = wel;
  assign o_cmd_err = cmd_err;

  always_comb begin
    case (opcode)
      OP_SSE:  erase_size = (AW+1)'(SUB_CLIP);
      OP_SE:   erase_size = (AW+1)'(SEC_CLIP);
      default: erase_size = (AW+1)'(MEM_BYTES);
    endcase
    erase_base = addr[AW-1:0] & ~AW'(erase_size - 1'b1);
  end

  // Single write port: the sweep and a page program never overlap because programming requires WIP=0
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = sweep_idx;
    mem_wdata = 8'hFF;
    if (op_state == ERASE_SWEEP) begin
      mem_we = 1'b1;
    end else if (state == PROG && byte_valid) begin
      mem_we    = 1'b1;
      mem_widx  = addr[AW-1:0];
      mem_wdata = mem[addr[AW-1:0]] & rx_byte;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state      <= IDLE;
      op_state   <= IDLE;
      addr       <= 24'd0;
      opcode     <= 8'd0;
      wel        <= 1'b0;
      wip        <= 1'b0;
      cmd_err    <= 1'b0;
      commit_ok  <= 1'b0;
      prog_any   <= 1'b0;
      tx_load    <= 1'b0;
      tx_data    <= 8'd0;
      busy_cnt   <= 16'd0;
      sweep_idx  <= '0;
      sweep_left <= '0;
    end else begin
      cmd_err <= 1'b0;
      tx_load <= 1'b0;

      case (op_state)
        ERASE_SWEEP: begin
          sweep_idx  <= sweep_idx + 1'b1;
          sweep_left <= sweep_left - 1'b1;
          if (sweep_left == (AW+1)'(1)) begin
            op_state <= BUSY;
            busy_cnt <= 16'(ERASE_EXTRA);
          end
        end
        BUSY: begin
          busy_cnt <= busy_cnt - 16'd1;
          if (busy_cnt <= 16'd1) begin
            op_state <= IDLE;
            wip      <= 1'b0;
            wel      <= 1'b0;
          end
        end
        default: ;
      endcase

      if (cs_fall) begin
        state     <= OPCODE;
        commit_ok <= 1'b0;
        prog_any  <= 1'b0;
      end else if (cs_rise) begin
        state <= IDLE;
        if (commit_ok) begin
          op_state   <= ERASE_SWEEP;
          wip        <= 1'b1;
          sweep_idx  <= erase_base;
          sweep_left <= erase_size;
        end else if (state == PROG && prog_any) begin
          op_state <= BUSY;
          wip      <= 1'b1;
          busy_cnt <= 16'(PROG_CYCLES);
        end
      end else if (byte_valid) begin
        tx_load   <= 1'b1;
        tx_data   <= 8'h00;
        commit_ok <= 1'b0;
        case (state)
          OPCODE: begin
            opcode <= rx_byte;
            state  <= IGNORE;
            case (rx_byte)
              OP_RDSR: begin
                state   <= STATUS;
                tx_data <= status_byte(wel, wip);
              end
              OP_WREN: if (!wip) wel <= 1'b1; else cmd_err <= 1'b1;
              OP_READ: if (!wip) state <= ADDR2; else cmd_err <= 1'b1;
              OP_PP, OP_SSE, OP_SE: if (wel && !wip) state <= ADDR2; else cmd_err <= 1'b1;
              OP_BE: if (wel && !wip) commit_ok <= 1'b1; else cmd_err <= 1'b1;
              default: cmd_err <= 1'b1;
            endcase
          end
          ADDR2: begin
            addr  <= addr_next;
            state <= ADDR1;
          end
          ADDR1: begin
            addr  <= addr_next;
            state <= ADDR0;
          end
          ADDR0: begin
            addr <= addr_next;
            case (opcode)
              OP_READ: begin
                state   <= READ;
                tx_data <= mem[addr_next[AW-1:0]];
                addr    <= addr_next + 24'd1;
              end
              OP_PP: state <= PROG;
              default: begin
                state     <= IGNORE;
                commit_ok <= 1'b1;
              end
            endcase
          end
          READ: begin
            tx_data <= mem[addr[AW-1:0]];
            addr    <= addr + 24'd1;
          end
          PROG: begin
            addr[7:0] <= addr[7:0] + 8'd1;
            prog_any  <= 1'b1;
          end
          STATUS: tx_data <= status_byte(wel, wip);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: status, write-enable gating, erase/program/read, wrap and reset abort.
module tb_spi_flash_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, wip, wel, cmd_err;

  int checks = 0;
  int failures = 0;
  int wip_total = 0;
  int err_total = 0;
  int w0, e0;
  logic [7:0] wb [8];
  logic [7:0] rb [8];

  always #5 clk = ~clk;

  spi_flash_responder #(
    .MEM_BYTES   (4096),
    .PROG_CYCLES (64),
    .ERASE_EXTRA (32)
  ) dut (
    .i_wb_clk  (clk),
    .i_wb_rst  (rst),
    .SCK       (sck),
    .CS_n      (cs_n),
    .MOSI      (mosi),
    .MISO      (miso),
    .o_wip     (wip),
    .o_wel     (wel),
    .o_cmd_err (cmd_err)
  );

  always @(negedge clk) begin
    if (wip === 1'b1) wip_total <= wip_total + 1;
    if (cmd_err === 1'b1) err_total <= err_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(4);
      rx[i] = miso;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic spi_cmd(input logic [7:0] op, input logic [23:0] a, input int naddr, input int n);
    logic [7:0] r;
    cs_n = 1'b0;
    tick(4);
    xfer(op, r);
    for (int i = 0; i < naddr; i++) xfer(a[23-8*i -: 8], r);
    for (int i = 0; i < n; i++) begin
      xfer(wb[i], r);
      rb[i] = r;
    end
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (wip === 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, wip}, 32'd0);
  endtask

  task automatic set_wb(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    wb[0] = d0; wb[1] = d1; wb[2] = d2; wb[3] = d3;
    for (int i = 4; i < 8; i++) wb[i] = 8'h00;
  endtask

  initial begin
    set_wb(8'h00, 8'h00, 8'h00, 8'h00);
    tick(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_wip", {31'd0, wip}, 32'd0);
    check("rst_wel", {31'd0, wel}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    tick(4);

    spi_cmd(8'h05, 24'd0, 0, 2);
    check("status_after_reset", rb[0], 32'h00);
    check("status_after_reset_b2", rb[1], 32'h00);

    e0 = err_total;
    spi_cmd(8'h02, 24'h000000, 3, 1);
    check("pp_without_wel_err", err_total - e0, 1);
    check("pp_without_wel_wel", {31'd0, wel}, 32'd0);

    spi_cmd(8'h06, 24'd0, 0, 0);
    spi_cmd(8'h05, 24'd0, 0, 1);
    check("status_after_wren", rb[0], 32'h02);
    check("wel_after_wren", {31'd0, wel}, 32'd1);

    w0 = wip_total;
    spi_cmd(8'h20, 24'h000100, 3, 0);
    check("wip_after_sse", {31'd0, wip}, 32'd1);
    e0 = err_total;
    spi_cmd(8'h03, 24'h000010, 3, 1);
    check("read_busy_err", err_total - e0, 1);
    spi_cmd(8'h05, 24'd0, 0, 1);
    check("status_during_erase", rb[0], 32'h03);
    wait_idle("erase_done", 6000);
    check("erase_wip_cycles", wip_total - w0, 4128);
    spi_cmd(8'h05, 24'd0, 0, 1);
    check("status_after_erase", rb[0], 32'h00);

    e0 = err_total;
    spi_cmd(8'h02, 24'h000020, 3, 1);
    check("pp_no_wel_err2", err_total - e0, 1);
    spi_cmd(8'h03, 24'h000020, 3, 1);
    check("pp_no_wel_unchanged", rb[0], 32'hFF);

    spi_cmd(8'h06, 24'd0, 0, 0);
    set_wb(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    w0 = wip_total;
    spi_cmd(8'h02, 24'h000010, 3, 4);
    wait_idle("prog_done", 500);
    check("prog_wip_cycles", wip_total - w0, 64);
    check("wel_after_prog", {31'd0, wel}, 32'd0);

    set_wb(8'h00, 8'h00, 8'h00, 8'h00);
    spi_cmd(8'h03, 24'h000010, 3, 4);
    check("read_0x10", rb[0], 32'hDE);
    check("read_0x11", rb[1], 32'hAD);
    check("read_0x12", rb[2], 32'hBE);
    check("read_0x13", rb[3], 32'hEF);
    spi_cmd(8'h03, 24'h001010, 3, 1);
    check("read_alias", rb[0], 32'hDE);

    spi_cmd(8'h06, 24'd0, 0, 0);
    spi_cmd(8'h20, 24'h000100, 2, 0);
    check("abort_erase_wip", {31'd0, wip}, 32'd0);
    check("abort_erase_wel", {31'd0, wel}, 32'd1);

    set_wb(8'h11, 8'h22, 8'h33, 8'h44);
    spi_cmd(8'h02, 24'h0000FE, 3, 4);
    wait_idle("wrap_prog_done", 500);
    set_wb(8'h00, 8'h00, 8'h00, 8'h00);
    spi_cmd(8'h03, 24'h0000FE, 3, 2);
    check("wrap_0xfe", rb[0], 32'h11);
    check("wrap_0xff", rb[1], 32'h22);
    spi_cmd(8'h03, 24'h000000, 3, 2);
    check("wrap_0x00", rb[0], 32'h33);
    check("wrap_0x01", rb[1], 32'h44);
    spi_cmd(8'h03, 24'h000100, 3, 1);
    check("wrap_0x100_untouched", rb[0], 32'hFF);

    spi_cmd(8'h06, 24'd0, 0, 0);
    set_wb(8'h0F, 8'h00, 8'h00, 8'h00);
    spi_cmd(8'h02, 24'h000010, 3, 1);
    wait_idle("nor_prog_done", 500);
    set_wb(8'h00, 8'h00, 8'h00, 8'h00);
    spi_cmd(8'h03, 24'h000010, 3, 1);
    check("nor_and", rb[0], 32'h0E);

    spi_cmd(8'h03, 24'h000FFF, 3, 2);
    check("read_top", rb[0], 32'hFF);
    check("read_wrap_mem", rb[1], 32'h33);

    spi_cmd(8'h06, 24'd0, 0, 0);
    spi_cmd(8'hC7, 24'd0, 0, 0);
    tick(40);
    check("bulk_erase_wip", {31'd0, wip}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wip", {31'd0, wip}, 32'd0);
    check("async_rst_wel", {31'd0, wel}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    spi_cmd(8'h05, 24'd0, 0, 1);
    check("status_after_abort", rb[0], 32'h00);
    spi_cmd(8'h03, 24'h000000, 3, 1);
    check("swept_before_abort", rb[0], 32'hFF);
    spi_cmd(8'h03, 24'h0000FE, 3, 1);
    check("not_swept_after_abort", rb[0], 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR-flash emulator that sits on the far end of the flash controller's SCK/CS_n/MOSI/MISO pins.
- Used in system simulation and on FPGA bring-up boards that have no physical flash.
- Decodes the same command set the controller issues and serves reads from an internal byte array.
- Models program/erase busy time and the status register (WIP, WEL), so the controller's polling, retry and write-enable paths are all exercised.

Parameters:
- MEM_BYTES, 4096: backing array size in bytes; power of two. Flash addresses alias modulo MEM_BYTES.
- PROG_CYCLES, 64: i_wb_clk cycles that WIP stays high after a page-program CS_n rise.
- ERASE_EXTRA, 32: i_wb_clk cycles WIP stays high after the erase sweep completes.

Ports:
- i_wb_clk  in  1  system clock; SCK half-period must be ≥3 cycles of it (benches use 4).
- i_wb_rst  in  1  asynchronous, active-high reset.
- SCK  in  1  SPI clock, mode 0 (sample on rise, shift on fall).
- CS_n  in  1  chip select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- o_wip  out  1  status bit 0 (write in progress).
- o_wel  out  1  status bit 1 (write enable latch).
- o_cmd_err  out  1  one-cycle pulse when an opcode is ignored (unknown, WEL=0, or WIP=1).

Behaviour:
- Reset values: MISO=0, o_wip=0, o_wel=0, o_cmd_err=0, FSM=IDLE. Array contents are undefined (no reset).
- Input sync: SCK, CS_n and MOSI each pass through 2 flops. Edges are detected on the synced copies.
  - A rising SCK edge is acted on 3 clocks after the pin edge.
  - MISO is registered and updates 1 clock after a detected rising edge.
- Byte framing:
  - 3-bit bit counter, shift-in register, shift-out register. Counter and registers clear when synced CS_n goes high.
  - Byte complete on the 8th rising edge. The next TX byte loads at that point, so its MSB is on MISO before the next rising edge.
- Status byte = {6'b0, WEL, WIP}.
- FSM states: IDLE, OPCODE, ADDR2, ADDR1, ADDR0, READ, PROG, STATUS, IGNORE, ERASE_SWEEP, BUSY.
  - CS_n fall → OPCODE.
  - CS_n rise in any transfer state → IDLE, unless an operation is committed (see below).
- OPCODE byte handling:
  - 0x05 → STATUS. The status byte is repeated for every following byte and WIP is re-sampled at each byte boundary. Allowed while WIP=1.
  - 0x06 → WEL=1, then IGNORE. Ignored while WIP=1.
  - 0x03 → ADDR2. Ignored while WIP=1.
  - 0x02 / 0x20 / 0xD8 → ADDR2 only if WEL=1 and WIP=0.
  - 0xC7 → wait for CS_n rise; commits a full erase if WEL=1 and WIP=0.
  - Any other opcode, or a disallowed case → IGNORE with an o_cmd_err pulse. MISO is 0 in IGNORE.
- Address: 24-bit, MSB byte first. Array index = addr mod MEM_BYTES.
- READ:
  - Array byte at addr is loaded into the TX shifter; address increments per byte and wraps at MEM_BYTES.
  - The first data byte follows the last address byte with no dummy byte.
- PROG:
  - Each received byte performs mem[addr] <= mem[addr] & byte (NOR semantics).
  - Address increments only addr[7:0], so writes wrap within the 256-byte page.
  - CS_n rise with ≥1 byte written → BUSY for PROG_CYCLES with WIP=1.
  - CS_n rise with 0 bytes written → IDLE, WEL unchanged.
  - A partial final byte is discarded.
- Erase:
  - 0x20 / 0xD8 commit only on a CS_n rise immediately after ADDR0 completes. A CS_n rise mid-address → IDLE with no effect.
  - Region size: subsector 4 KiB, sector 64 KiB, full = MEM_BYTES. Each is clipped to MEM_BYTES and aligned down to the region base.
  - ERASE_SWEEP writes 0xFF at one byte per clock.
  - After the sweep, BUSY runs for ERASE_EXTRA cycles.
  - WIP=1 from commit until BUSY ends.
- WEL clears when a program or erase completes (at BUSY end). It is unaffected by reads and by ignored commands.
- SPI transactions during ERASE_SWEEP/BUSY proceed in parallel with the sweep; only status reads are served.
- An asynchronous reset mid-operation aborts any sweep or busy period immediately; already-written bytes stay written.

Decomposition:
- Package spi_flash_pkg: opcode constants (0x05, 0x06, 0x02, 0x20, 0xD8, 0xC7, 0x03), status bit indices, region sizes, FSM state enum. The flash controller shares the opcode constants.
- Sub-module spi_slave_shifter: input synchronizers, edge detect, bit counter, shift-in/shift-out, byte_valid / tx_load handshake.

Test Plan:
- Status poll after reset: send 0x05 + dummy → MISO byte 0x00; o_wip=0.
- Write-enable gating: 0x02 with no prior 0x06 → o_cmd_err pulse, array unchanged. Then 0x06, CS rise, 0x05 → status 0x02.
- Erase, program, read-back:
  - 0x06; 0x20 addr 0x000100 → WIP=1 for 4096 + 32 cycles, then status 0x00.
  - 0x06; 0x02 addr 0x000010 data DE AD BE EF.
  - 0x03 addr 0x000010 → DE AD BE EF.
- Page wrap: program 4 bytes at 0x0000FE → bytes land at 0xFE, 0xFF, 0x00, 0x01; byte 0x100 stays 0xFF.
- Busy rejection: 0x03 issued during erase BUSY → o_cmd_err. A 0x05 issued at the same time returns 0x03 (WEL=1, WIP=1).
- Reset during ERASE_SWEEP: o_wip returns to 0 asynchronously. A later 0x05 → 0x00.
